// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and defaults for the FIFO-fed serial transmitter.
// The state encoding is visible on the top-level debug port.
package fifo_serial_tx_pkg;

    localparam int WIDTH_DEF = 3;
    localparam int DIV_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_e;

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// Bit-period down-counter: reload to DIV-1, count to zero, tick while at zero.
// The counter parks at zero until the next load.
module bit_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);
    localparam int TW = $clog2(DIV);
    localparam logic [TW-1:0] RELOAD = TW'(DIV - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops one word at a time from a FIFO and sends it as START, WIDTH data bits
// (LSB first) and STOP, each held for DIV clocks. tx is registered.
module fifo_serial_tx
    import fifo_serial_tx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIV   = DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             empty,
    output logic             re,
    input  logic [WIDTH-1:0] rdata,
    output logic             tx,
    output logic             busy,
    output logic [7:0]       frame_count,
    output logic [2:0]       state_dbg
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             tx_q, tx_d;
    logic [7:0]       frame_count_q, frame_count_d;
    logic             timer_load;
    logic             tick;

    bit_timer #(.DIV(DIV)) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .tick (tick)
    );

    // FIFO handshake: re is a one-cycle pulse, only in IDLE with empty low;
    // the word on rdata is taken in the following (WAIT) cycle.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        frame_count_d = frame_count_q;
        timer_load    = 1'b0;
        re            = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !empty && !rst) begin
                    re      = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                shreg_d    = rdata;
                timer_load = 1'b1;
                state_d    = START;
            end
            START: begin
                if (tick) begin
                    timer_load = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    timer_load = 1'b1;
                    shreg_d    = shreg_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is derived from the next state so the registered line lines up with it
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            tx_q          <= 1'b1;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_q          <= tx_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign tx          = tx_q;
    assign busy        = (state_q != IDLE) || re;
    assign frame_count = frame_count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Self-checking bench for fifo_serial_tx: directed table of frames, corner
// sequences, and randomized traffic against a per-cycle waveform schedule.
module tb_fifo_serial_tx;
    localparam int W     = 3;
    localparam int DIV   = 4;
    localparam int FRAME = (W + 2) * DIV;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         empty = 1'b1;
    logic [W-1:0] rdata = '0;
    logic         re;
    logic         tx;
    logic         busy;
    logic [7:0]   frame_count;
    logic [2:0]   state_dbg;

    fifo_serial_tx #(.WIDTH(W), .DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .empty       (empty),
        .re          (re),
        .rdata       (rdata),
        .tx          (tx),
        .busy        (busy),
        .frame_count (frame_count),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] word;
        logic [4:0]   slots;  // expected line level per slot: start, b0..b2, stop
    } vec_t;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    bit           chk_on = 0;
    bit           force_empty = 0;
    logic [W-1:0] fifo_q[$];
    logic [1:0]   exp_q[$];  // per future cycle: {last_stop_cycle, tx}
    int           m_fc = 0;
    logic         last_re, last_tx, last_busy;
    logic [7:0]   last_fc;
    logic [2:0]   last_state;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] w);
        exp_q.push_back(2'b01);
        for (int i = 0; i < DIV; i++) exp_q.push_back(2'b00);
        for (int b = 0; b < W; b++)
            for (int i = 0; i < DIV; i++) exp_q.push_back({1'b0, w[b]});
        for (int i = 0; i < DIV; i++) exp_q.push_back({(i == DIV - 1), 1'b1});
    endtask

    task automatic model_step();
        logic       e_re, e_tx, e_busy, e_last;
        logic [1:0] ent;
        if (exp_q.size() == 0) begin
            e_re   = !rst && en && !empty;
            e_tx   = 1'b1;
            e_busy = e_re;
            e_last = 1'b0;
        end else begin
            ent    = exp_q.pop_front();
            e_re   = 1'b0;
            e_tx   = ent[0];
            e_busy = 1'b1;
            e_last = ent[1];
        end
        chk("re", re, e_re);
        chk("tx", tx, e_tx);
        chk("busy", busy, e_busy);
        chk("frame_count", frame_count, 32'(m_fc));
        if (rst) begin
            exp_q.delete();
            m_fc = 0;
        end else begin
            if (e_last) m_fc = (m_fc + 1) % 256;
            if (e_re) push_frame(fifo_q[0]);
        end
    endtask

    task automatic cycle();
        empty = force_empty || (fifo_q.size() == 0);
        @(negedge clk);
        if (chk_on) model_step();
        last_re    = re;
        last_tx    = tx;
        last_busy  = busy;
        last_fc    = frame_count;
        last_state = state_dbg;
        @(posedge clk);
        #1;
        if (last_re && fifo_q.size() > 0) rdata = fifo_q.pop_front();
        cyc++;
    endtask

    task automatic wait_re(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            cycle();
            if (last_re) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        logic wave[0:31];
        bit   ok, good;
        int   re_cnt, t1, t2, tx_low, busy_seen;

        vecs[0] = '{3'b101, 5'b11010};
        vecs[1] = '{3'b001, 5'b10010};
        vecs[2] = '{3'b110, 5'b11100};
        vecs[3] = '{3'b000, 5'b10000};
        vecs[4] = '{3'b111, 5'b11110};

        // reset, with a pending word and en high: no read while rst is high
        cycle();
        cycle();
        en = 1'b1;
        fifo_q.push_back(3'b111);
        cycle();
        chk("re_during_rst", last_re, 0);
        fifo_q.delete();
        en = 1'b0;
        rst = 1'b0;
        chk_on = 1'b1;
        cycle();
        chk("rst_tx", last_tx, 1);
        chk("rst_busy", last_busy, 0);
        chk("rst_fc", last_fc, 0);
        chk("rst_state", last_state, 0);

        // table of single frames
        for (int v = 0; v < 5; v++) begin
            fifo_q.push_back(vecs[v].word);
            en = 1'b1;
            wait_re(40, ok);
            chk("tbl_re", ok, 1);
            for (int k = 1; k <= FRAME + 1; k++) begin
                cycle();
                wave[k] = last_tx;
            end
            chk("tbl_wait_tx", wave[1], 1);
            for (int s = 0; s < 5; s++) begin
                good = 1'b1;
                for (int j = 0; j < DIV; j++)
                    if (wave[2 + s * DIV + j] !== vecs[v].slots[s]) good = 1'b0;
                chk("tbl_slot", good, 1);
            end
            en = 1'b0;
            cycle();
            chk("tbl_fc", last_fc, v + 1);
            chk("tbl_idle_busy", last_busy, 0);
        end

        // empty held high with en high
        fifo_q.push_back(3'b010);
        force_empty = 1'b1;
        en = 1'b1;
        re_cnt = 0;
        tx_low = 0;
        busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (last_re) re_cnt++;
            if (!last_tx) tx_low++;
            if (last_busy) busy_seen++;
        end
        chk("empty_re", re_cnt, 0);
        chk("empty_tx_low", tx_low, 0);
        chk("empty_busy", busy_seen, 0);
        fifo_q.delete();
        force_empty = 1'b0;

        // back-to-back words
        do_reset();
        fifo_q.push_back(3'b001);
        fifo_q.push_back(3'b110);
        en = 1'b1;
        wait_re(40, ok);
        chk("b2b_re1", ok, 1);
        t1 = cyc;
        wait_re(60, ok);
        chk("b2b_re2", ok, 1);
        t2 = cyc;
        chk("b2b_spacing", t2 - t1, FRAME + 2);
        repeat (FRAME + 2) cycle();
        chk("b2b_fc", last_fc, 2);

        // reset on the second data bit
        fifo_q.push_back(3'b101);
        wait_re(40, ok);
        chk("rstmid_re", ok, 1);
        repeat (1 + 2 * DIV) cycle();
        rst = 1'b1;
        cycle();
        chk("rstmid_tx_before", last_tx, 0);
        rst = 1'b0;
        cycle();
        chk("rstmid_tx", last_tx, 1);
        chk("rstmid_busy", last_busy, 0);
        chk("rstmid_fc", last_fc, 0);
        re_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (last_re) re_cnt++;
        end
        chk("rstmid_no_reread", re_cnt, 0);

        // en dropped in first START cycle
        fifo_q.push_back(3'b010);
        fifo_q.push_back(3'b100);
        en = 1'b1;
        wait_re(40, ok);
        chk("endrop_re", ok, 1);
        cycle();
        en = 1'b0;
        re_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (last_re) re_cnt++;
        end
        chk("endrop_no_re", re_cnt, 0);
        chk("endrop_fifo_left", fifo_q.size(), 1);
        chk("endrop_fc", last_fc, 1);
        fifo_q.delete();

        // 256 frames: frame_count wraps
        do_reset();
        for (int i = 0; i < 256; i++) fifo_q.push_back(W'($urandom_range(0, 7)));
        en = 1'b1;
        re_cnt = 0;
        for (int i = 0; i < 256 * (FRAME + 2) + 10 && re_cnt < 256; i++) begin
            cycle();
            if (last_re) re_cnt++;
        end
        repeat (FRAME + 2) cycle();
        chk("wrap_re_cnt", re_cnt, 256);
        chk("wrap_fc", last_fc, 0);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 9) < 7);
            force_empty = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) fifo_q.push_back(W'($urandom_range(0, 7)));
            cycle();
        end
        rst = 1'b0;
        force_empty = 1'b0;
        en = 1'b0;
        repeat (FRAME + 4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_serial_tx.md
FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 Parameter WIDTH, default 3, data word width; matches the FIFO read-data width.
REQ-002 Parameter DIV, default 4, clk cycles per serial bit; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  permits starting a new frame; has no effect on a frame already in progress.
REQ-006 empty  input  1  FIFO read-side empty flag.
REQ-007 re  output  1  FIFO read enable; a single-cycle pulse per word.
REQ-008 rdata  input  WIDTH  FIFO read data; valid one clk after the cycle in which re is high.
REQ-009 tx  output  1  serial line; idles high.
REQ-010 busy  output  1  high from the re cycle through the last STOP cycle.
REQ-011 frame_count  output  8  count of completed frames.

Function
REQ-012 The FSM shall have the states IDLE, WAIT, START, DATA and STOP.
REQ-013 IDLE: when en=1 and empty=0, re shall be 1 combinationally in that cycle and the next state shall be WAIT; otherwise the FSM stays in IDLE with re=0.
REQ-014 re shall never be 1 while empty=1 or outside IDLE.
REQ-015 WAIT: latch rdata into the shift register and go to START; WAIT lasts exactly 1 cycle.
REQ-016 START: tx=0 for DIV cycles, then go to DATA.
REQ-017 DATA: shift WIDTH bits out LSB first, each held for DIV cycles, then go to STOP.
REQ-018 STOP: tx=1 for DIV cycles; on the last STOP cycle frame_count increments and the FSM returns to IDLE.
REQ-019 frame_count shall wrap from 255 to 0 with no flag.
REQ-020 Frame length shall be exactly (WIDTH+2)*DIV cycles, measured from the first START cycle to the end of the last STOP cycle.
REQ-021 Back-to-back words: the minimum spacing between consecutive re pulses shall be (WIDTH+2)*DIV+2 cycles.
REQ-022 tx shall be registered and glitch-free; tx=1 in IDLE and in WAIT.
REQ-023 busy shall be 1 in WAIT, START, DATA and STOP, and also in the IDLE cycle in which re=1.
REQ-024 If en falls mid-frame, the current frame shall complete and no new re shall be issued.
REQ-025 empty rising during a frame shall have no effect; empty is sampled only in IDLE.

Reset
REQ-026 With rst=1 at a clock edge, on the next cycle the state shall be IDLE, tx=1, busy=0, re=0, frame_count=0, and the shift register and bit timer shall be 0.
REQ-027 rst shall take precedence over every other input, including mid-frame: the partial frame is discarded, no FIFO word is re-read, and frame_count does not increment.
REQ-028 While rst=1, re shall be 0 regardless of en and empty.

Structure
REQ-029 Package fifo_serial_tx_pkg shall hold the state enum (IDLE, WAIT, START, DATA, STOP) and the default constants WIDTH_DEF=3 and DIV_DEF=4.
REQ-030 Sub-module bit_timer shall be a down-counter of width clog2(DIV).
REQ-031 bit_timer shall be loaded with DIV-1 on state entry or bit advance, and shall assert tick when it reaches 0.
REQ-032 A bit counter of width clog2(WIDTH+1) shall track DATA progress in the top module.

Verification
REQ-033 WIDTH=3, DIV=4, empty falls to 0 with en=1 and rdata=3'b101 -> one re pulse; then tx = 0x4, 1x4, 0x4, 1x4, 1x4 starting 2 cycles after re; frame_count=1.
REQ-034 empty held at 1 for 100 cycles with en=1 -> re=0 throughout, tx=1, busy=0.
REQ-035 Words 3'b001 and 3'b110 with empty=0 continuously -> re pulses 22 cycles apart; both frames bit-exact; frame_count=2.
REQ-036 rst=1 on the 2nd DATA bit -> tx=1, busy=0, frame_count=0 on the next cycle; no re for that word.
REQ-037 en dropped in the first START cycle -> frame completes; no further re while en=0.
REQ-038 256 consecutive frames -> frame_count wraps to 0.
